// File: rtl/debug_mem_pkg.sv
// Shared types and constants for the debug cache-port initiator.
package debug_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    VWR,
    RESP
  } state_t;

  localparam logic SEL_DCACHE = 1'b0;
  localparam logic SEL_ICACHE = 1'b1;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 7;
  localparam int CNT_W        = 3;

  typedef struct packed {
    logic        write;
    logic        sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cmd_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/debug_mem_master.sv
// Single-outstanding read/write initiator for the core's InstCache/DataCache debug ports.
// Optional write read-back verification is built when DEBUG_WRITE_VERIFY_EN is defined.
//
// state | meaning
// IDLE  | ready for a command
// ISSUE | selected port driven; write strobe active for this cycle only
// VWR   | write done, address held so the same word is read back
// WAIT  | counting down the memory read latency
// RESP  | response held until the host takes it
module debug_mem_master
  import debug_mem_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_sel,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] dbg_dc_a2,
  output logic [31:0] dbg_dc_wd2,
  output logic [3:0]  dbg_dc_we2,
  input  logic [31:0] dbg_dc_rd2,
  output logic [31:0] dbg_ic_a2,
  output logic [31:0] dbg_ic_wd2,
  output logic [3:0]  dbg_ic_we2,
  input  logic [31:0] dbg_ic_rd2,
  output logic        busy
);

  if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_lat_check
    $error("debug_mem_master: READ_LAT must be within 1..7");
  end

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(READ_LAT - 1);

  state_t           state;
  logic             sel_q;
  logic             write_q;
  logic [CNT_W-1:0] cnt;
  rsp_t             rsp_q;
  logic             rsp_valid_q;
  cmd_t             cmd_in;
  logic [31:0]      rd_sel;
  logic             vfy_err;

  assign cmd_in = '{write: cmd_write, sel: cmd_sel, addr: cmd_addr,
                    wdata: cmd_wdata, be: cmd_be};

  assign rd_sel = (sel_q == SEL_ICACHE) ? dbg_ic_rd2 : dbg_dc_rd2;

`ifdef DEBUG_WRITE_VERIFY_EN
  logic [3:0]  vbe_q;
  logic [31:0] wd_sel;

  // The write data is still sitting in the selected port's WD2 register.
  assign wd_sel  = (sel_q == SEL_ICACHE) ? dbg_ic_wd2 : dbg_dc_wd2;
  assign vfy_err = write_q && (((rd_sel ^ wd_sel) & be_to_mask(vbe_q)) != '0);
`else
  assign vfy_err = 1'b0;
`endif

  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      state       <= IDLE;
      sel_q       <= SEL_DCACHE;
      write_q     <= 1'b0;
      cnt         <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      dbg_dc_a2   <= '0;
      dbg_dc_wd2  <= '0;
      dbg_dc_we2  <= '0;
      dbg_ic_a2   <= '0;
      dbg_ic_wd2  <= '0;
      dbg_ic_we2  <= '0;
`ifdef DEBUG_WRITE_VERIFY_EN
      vbe_q       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            sel_q   <= cmd_in.sel;
            write_q <= cmd_in.write;
            if (cmd_in.addr[1:0] != 2'b00) begin
              rsp_q       <= '{rdata: 32'h0, err: 1'b1};
              rsp_valid_q <= 1'b1;
              state       <= RESP;
            end else begin
              rsp_q <= '0;
              // Port registers load on accept so the strobe lands in the ISSUE cycle.
              if (cmd_in.sel == SEL_ICACHE) begin
                dbg_ic_a2  <= cmd_in.addr;
                dbg_ic_wd2 <= cmd_in.wdata;
                dbg_ic_we2 <= cmd_in.write ? 4'hF : 4'h0;
              end else begin
                dbg_dc_a2  <= cmd_in.addr;
                dbg_dc_wd2 <= cmd_in.wdata;
                dbg_dc_we2 <= cmd_in.write ? cmd_in.be : 4'h0;
              end
`ifdef DEBUG_WRITE_VERIFY_EN
              vbe_q <= (cmd_in.sel == SEL_ICACHE) ? 4'hF : cmd_in.be;
`endif
              state <= ISSUE;
            end
          end
        end

        ISSUE: begin
          dbg_dc_we2 <= '0;
          dbg_ic_we2 <= '0;
          if (write_q) begin
`ifdef DEBUG_WRITE_VERIFY_EN
            state <= VWR;
`else
            rsp_valid_q <= 1'b1;
            state       <= RESP;
`endif
          end else begin
            cnt   <= LAT_M1;
            state <= WAIT;
          end
        end

`ifdef DEBUG_WRITE_VERIFY_EN
        VWR: begin
          cnt   <= LAT_M1;
          state <= WAIT;
        end
`endif

        WAIT: begin
          if (cnt == '0) begin
            rsp_q       <= '{rdata: rd_sel, err: vfy_err};
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_debug_mem_master.sv
// Directed bench for debug_mem_master with BRAM models and a response scoreboard.
module tb_debug_mem_master;

  localparam int READ_LAT = 1;
`ifdef DEBUG_WRITE_VERIFY_EN
  localparam int WR_LAT = 3 + READ_LAT;
`else
  localparam int WR_LAT = 2;
`endif
  localparam int RD_LAT = READ_LAT + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0, cmd_sel = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_be = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] dc_a2, dc_wd2, dc_rd2, ic_a2, ic_wd2, ic_rd2;
  logic [3:0]  dc_we2, ic_we2;
  logic        busy;

  always #5 clk = ~clk;

  debug_mem_master #(.READ_LAT(READ_LAT)) dut (
    .CPU_CLK(clk), .CPU_RST(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dbg_dc_a2(dc_a2), .dbg_dc_wd2(dc_wd2), .dbg_dc_we2(dc_we2), .dbg_dc_rd2(dc_rd2),
    .dbg_ic_a2(ic_a2), .dbg_ic_wd2(ic_wd2), .dbg_ic_we2(ic_we2), .dbg_ic_rd2(ic_rd2),
    .busy(busy)
  );

  // Synchronous-read BRAMs, one cycle latency, read-first on a same-edge write.
  logic [31:0] mem_dc [0:255];
  logic [31:0] mem_ic [0:255];
  logic [31:0] dc_rd_q = '0, ic_rd_q = '0;
  logic        corrupt = 1'b0;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (dc_we2[b]) mem_dc[dc_a2[9:2]][8*b +: 8] <= dc_wd2[8*b +: 8];
      if (ic_we2[b]) mem_ic[ic_a2[9:2]][8*b +: 8] <= ic_wd2[8*b +: 8];
    end
    dc_rd_q <= mem_dc[dc_a2[9:2]];
    ic_rd_q <= mem_ic[ic_a2[9:2]];
  end
  assign dc_rd2 = dc_rd_q ^ {31'b0, corrupt};
  assign ic_rd2 = ic_rd_q ^ {31'b0, corrupt};

  int          cyc = 0;
  int          dc_we_cnt = 0, ic_we_cnt = 0, overlap = 0;
  logic [3:0]  dc_we_last = '0, ic_we_last = '0;
  logic [31:0] dc_we_a2 = '0, ic_we_a2 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dc_we2 != 4'h0) begin dc_we_cnt++; dc_we_last = dc_we2; dc_we_a2 = dc_a2; end
    if (ic_we2 != 4'h0) begin ic_we_cnt++; ic_we_last = ic_we2; ic_we_a2 = ic_a2; end
    if (dc_we2 != 4'h0 && ic_we2 != 4'h0) overlap++;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] ref_dc [0:255];
  logic [31:0] ref_ic [0:255];

  int total = 0;
  int bad = 0;
  int acc_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic push_exp(input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  task automatic send(input logic wr, input logic sel, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be);
    int n;
    n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("cmd_ready_wait", {31'b0, cmd_ready}, 32'h1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_sel = sel;
    cmd_addr = addr; cmd_wdata = wdata; cmd_be = be;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic write_cmd(input logic sel, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    logic [31:0] nw;
    if (sel) begin
      nw = wdata;
      ref_ic[addr[9:2]] = nw;
    end else begin
      nw = merge(ref_dc[addr[9:2]], wdata, be);
      ref_dc[addr[9:2]] = nw;
    end
`ifdef DEBUG_WRITE_VERIFY_EN
    push_exp(nw, 1'b0);
`else
    push_exp(32'h0, 1'b0);
`endif
    send(1'b1, sel, addr, wdata, be);
  endtask

  task automatic read_cmd(input logic sel, input logic [31:0] addr);
    push_exp(sel ? ref_ic[addr[9:2]] : ref_dc[addr[9:2]], 1'b0);
    send(1'b0, sel, addr, 32'h0, 4'h0);
  endtask

  task automatic get_rsp(input string tag, input int hold, input int exp_lat);
    int          n;
    exp_t        e;
    logic [31:0] rd0;
    n = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check({tag, "_valid"}, {31'b0, rsp_valid}, 32'h1);
    check({tag, "_latency"}, 32'(cyc - acc_cyc + 1), 32'(exp_lat));
    if (sb.size() > 0) e = sb.pop_front();
    else begin e.rdata = 32'hx; e.err = 1'bx; end
    check({tag, "_rdata"}, rsp_rdata, e.rdata);
    check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
    rd0 = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'b0, rsp_valid}, 32'h1);
      check({tag, "_hold_rdata"}, rsp_rdata, rd0);
      check({tag, "_hold_cmd_ready"}, {31'b0, cmd_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  int          dc0, ic0, acc1;
  logic [31:0] a2_save;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_dc[i] = '0; mem_ic[i] = '0; ref_dc[i] = '0; ref_ic[i] = '0;
    end

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", {31'b0, rsp_err}, 32'h0);
    check("rst_a2", dc_a2 | ic_a2 | dc_wd2 | ic_wd2, 32'h0);
    check("rst_we2", {24'b0, dc_we2, ic_we2}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;

    // DataCache full-word write
    dc0 = dc_we_cnt; ic0 = ic_we_cnt;
    write_cmd(1'b0, 32'h100, 32'hDEADBEEF, 4'hF);
    get_rsp("wr_dc", 0, WR_LAT);
    check("wr_dc_we_cycles", 32'(dc_we_cnt - dc0), 32'h1);
    check("wr_dc_we_value", {28'b0, dc_we_last}, 32'hF);
    check("wr_dc_we_a2", dc_we_a2, 32'h100);
    check("wr_dc_ic_quiet", 32'(ic_we_cnt - ic0), 32'h0);

    read_cmd(1'b0, 32'h100);
    get_rsp("rd_dc", 0, RD_LAT);

    // InstCache write ignores byte enables
    dc0 = dc_we_cnt; ic0 = ic_we_cnt;
    write_cmd(1'b1, 32'h4, 32'hCAFEF00D, 4'h3);
    get_rsp("wr_ic", 0, WR_LAT);
    check("wr_ic_we_value", {28'b0, ic_we_last}, 32'hF);
    check("wr_ic_we_cycles", 32'(ic_we_cnt - ic0), 32'h1);
    check("wr_ic_dc_quiet", 32'(dc_we_cnt - dc0), 32'h0);
    read_cmd(1'b1, 32'h4);
    get_rsp("rd_ic", 0, RD_LAT);

    write_cmd(1'b0, 32'h100, 32'h11112222, 4'h3);
    get_rsp("wr_dc_part", 0, WR_LAT);
    read_cmd(1'b0, 32'h100);
    get_rsp("rd_dc_part", 0, RD_LAT);

    // Zero byte-enable write has no effect and no error
    dc0 = dc_we_cnt;
    write_cmd(1'b0, 32'h104, 32'hFFFFFFFF, 4'h0);
    get_rsp("wr_be0", 0, WR_LAT);
    check("wr_be0_no_strobe", 32'(dc_we_cnt - dc0), 32'h0);
    read_cmd(1'b0, 32'h104);
    get_rsp("rd_be0", 0, RD_LAT);

    // Misaligned read: error, no port activity
    dc0 = dc_we_cnt; ic0 = ic_we_cnt; a2_save = dc_a2;
    push_exp(32'h0, 1'b1);
    send(1'b0, 1'b0, 32'h102, 32'h0, 4'h0);
    get_rsp("misalign", 0, 1);
    check("misalign_a2", dc_a2, a2_save);
    check("misalign_we", 32'(dc_we_cnt - dc0 + ic_we_cnt - ic0), 32'h0);

    // Host back-pressure
    read_cmd(1'b0, 32'h100);
    get_rsp("hold", 5, RD_LAT);
    @(negedge clk);
    check("hold_release_valid", {31'b0, rsp_valid}, 32'h0);
    check("hold_release_ready", {31'b0, cmd_ready}, 32'h1);

    // Back-to-back writes
    write_cmd(1'b0, 32'h108, 32'h01020304, 4'hF);
    acc1 = acc_cyc;
    get_rsp("b2b_a", 0, WR_LAT);
    write_cmd(1'b0, 32'h10C, 32'h05060708, 4'hF);
    check("b2b_period", 32'(acc_cyc - acc1), 32'(WR_LAT + 1));
    get_rsp("b2b_b", 0, WR_LAT);

    // Reset while waiting on read data
    send(1'b0, 1'b0, 32'h108, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    check("mid_busy", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'b0, cmd_ready}, 32'h1);
    check("mid_rst_busy", {31'b0, busy}, 32'h0);
    check("mid_rst_rsp", {31'b0, rsp_valid}, 32'h0);
    check("mid_rst_a2", dc_a2, 32'h0);
    check("mid_rst_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_rst_no_rsp", {31'b0, rsp_valid}, 32'h0);
    end
    check("sb_empty", 32'(sb.size()), 32'h0);

    read_cmd(1'b0, 32'h108);
    get_rsp("rd_after_rst", 0, RD_LAT);

`ifdef DEBUG_WRITE_VERIFY_EN
    // Read-back disagrees with written data in bit 0
    ref_dc[32'h200 >> 2] = 32'h12345678;
    push_exp(32'h12345679, 1'b1);
    corrupt = 1'b1;
    send(1'b1, 1'b0, 32'h200, 32'h12345678, 4'hF);
    get_rsp("vfy_corrupt", 0, WR_LAT);
    corrupt = 1'b0;
`endif

    check("we_overlap", 32'(overlap), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
